// File: rtl/noc_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : noc_port_arbiter
// Purpose  : Per-output round-robin arbiter for the NoC router crossbar.
//            Each input presents a destination code. Every output grants at
//            most one input in the same cycle. A multi-flit packet keeps its
//            output locked until its tail flit is granted. Per-input fail and
//            registered starvation flags are reported.
// Ports    : clk, rst_n      - clock, asynchronous active-low reset
//            stall           - freeze all state, suppress all grants
//            req_dst         - destination code per input (0 = none,
//                              k = output k-1, codes above N_OUT = none)
//            req_tail        - current flit of input i is a packet tail
//            grant / fail    - per-input result of this cycle
//            out_vld/out_src - per-output crossbar select
//            starve          - registered, wait count >= STARVE_TH
// Options  : NOC_STARVE_PRIO_EN - starving inputs win unlocked outputs first
// Revision : 1.0 - initial release
// ============================================================================
module noc_port_arbiter #(
    parameter int N_IN      = 3,
    parameter int N_OUT     = 3,
    parameter int DST_W     = 2,
    parameter int SRC_W     = 2,
    parameter int WAIT_W    = 3,
    parameter int STARVE_TH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   stall,
    input  logic [N_IN*DST_W-1:0]  req_dst,
    input  logic [N_IN-1:0]        req_tail,
    output logic [N_IN-1:0]        grant,
    output logic [N_IN-1:0]        fail,
    output logic [N_OUT-1:0]       out_vld,
    output logic [N_OUT*SRC_W-1:0] out_src,
    output logic [N_IN-1:0]        starve
);

    localparam logic [WAIT_W-1:0] C_WAIT_MAX  = '1;
    localparam logic [WAIT_W-1:0] C_STARVE_TH = WAIT_W'(STARVE_TH);

    // State
    logic [SRC_W-1:0]  r_rr_ptr   [N_OUT];
    logic [SRC_W-1:0]  r_lock_own [N_OUT];
    logic [N_OUT-1:0]  r_lock_vld;
    logic [WAIT_W-1:0] r_wait     [N_IN];
    logic [N_IN-1:0]   r_starve;

    // Combinational
    logic [N_IN-1:0]   w_req      [N_OUT];  // w_req[o][i]: input i wants output o
    logic [N_IN-1:0]   w_any_req;
    logic [N_OUT-1:0]  w_win_vld;
    logic [N_OUT-1:0]  w_win_tail;
    logic [SRC_W-1:0]  w_win_idx  [N_OUT];
    logic [SRC_W-1:0]  w_rr_next  [N_OUT];
    logic [N_IN-1:0]   w_grant_raw;
    logic [WAIT_W-1:0] w_wait_next [N_IN];

    // Destination decode; codes above N_OUT match no output and act as none.
    always_comb begin
        w_any_req = '0;
        for (int o = 0; o < N_OUT; o++) begin
            for (int i = 0; i < N_IN; i++) begin
                w_req[o][i] = (req_dst[i*DST_W +: DST_W] == DST_W'(o + 1));
                w_any_req[i] = w_any_req[i] | w_req[o][i];
            end
        end
    end

    always_comb begin : p_arb
        int c;
        c           = 0;
        w_grant_raw = '0;
        w_win_vld   = '0;
        w_win_tail  = '0;
        for (int o = 0; o < N_OUT; o++) begin
            w_win_idx[o] = '0;
            w_rr_next[o] = '0;
            // A lock whose owner still asks for this output wins outright.
            for (int i = 0; i < N_IN; i++) begin
                if (r_lock_vld[o] && (r_lock_own[o] == SRC_W'(i)) && w_req[o][i]) begin
                    w_win_vld[o] = 1'b1;
                    w_win_idx[o] = SRC_W'(i);
                end
            end
`ifdef NOC_STARVE_PRIO_EN
            // First pass over starving requesters in round-robin order.
            for (int k = 0; k < N_IN; k++) begin
                c = (int'(r_rr_ptr[o]) + k) % N_IN;
                for (int i = 0; i < N_IN; i++) begin
                    if (!w_win_vld[o] && (i == c) && w_req[o][i] && r_starve[i]) begin
                        w_win_vld[o] = 1'b1;
                        w_win_idx[o] = SRC_W'(i);
                    end
                end
            end
`endif
            // Otherwise (no lock, or lock abandoned) plain rotated scan.
            for (int k = 0; k < N_IN; k++) begin
                c = (int'(r_rr_ptr[o]) + k) % N_IN;
                for (int i = 0; i < N_IN; i++) begin
                    if (!w_win_vld[o] && (i == c) && w_req[o][i]) begin
                        w_win_vld[o] = 1'b1;
                        w_win_idx[o] = SRC_W'(i);
                    end
                end
            end
            for (int i = 0; i < N_IN; i++) begin
                if (w_win_vld[o] && (w_win_idx[o] == SRC_W'(i))) begin
                    w_grant_raw[i] = 1'b1;
                    w_win_tail[o]  = req_tail[i];
                    w_rr_next[o]   = SRC_W'((i + 1) % N_IN);
                end
            end
        end
    end

    always_comb begin
        grant   = '0;
        fail    = '0;
        out_vld = '0;
        out_src = '0;
        if (!stall) begin
            grant   = w_grant_raw;
            fail    = w_any_req & ~w_grant_raw;
            out_vld = w_win_vld;
            for (int o = 0; o < N_OUT; o++) begin
                if (w_win_vld[o]) begin
                    out_src[o*SRC_W +: SRC_W] = w_win_idx[o];
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N_IN; i++) begin
            if (w_grant_raw[i] || !w_any_req[i]) begin
                w_wait_next[i] = '0;
            end else if (r_wait[i] == C_WAIT_MAX) begin
                w_wait_next[i] = C_WAIT_MAX;
            end else begin
                w_wait_next[i] = r_wait[i] + WAIT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lock_vld <= '0;
            r_starve   <= '0;
            for (int o = 0; o < N_OUT; o++) begin
                r_rr_ptr[o]   <= '0;
                r_lock_own[o] <= '0;
            end
            for (int i = 0; i < N_IN; i++) begin
                r_wait[i] <= '0;
            end
        end else if (!stall) begin
            for (int o = 0; o < N_OUT; o++) begin
                if (w_win_vld[o]) begin
                    if (w_win_tail[o]) begin
                        r_lock_vld[o] <= 1'b0;
                        r_rr_ptr[o]   <= w_rr_next[o];
                    end else begin
                        r_lock_vld[o] <= 1'b1;
                        r_lock_own[o] <= w_win_idx[o];
                    end
                end else if (r_lock_vld[o]) begin
                    // Nobody won, so the owner has left: drop the stale lock.
                    r_lock_vld[o] <= 1'b0;
                end
            end
            for (int i = 0; i < N_IN; i++) begin
                r_wait[i]   <= w_wait_next[i];
                r_starve[i] <= (w_wait_next[i] >= C_STARVE_TH);
            end
        end
    end

    assign starve = r_starve;

endmodule
`default_nettype wire
